// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_responder_pkg;

    localparam int DMEM_STATE_LENGTH = 2;
    localparam int DMEM_BE_LENGTH    = 4;
    localparam int DMEM_WAIT_LENGTH  = 4;

    typedef enum logic [DMEM_STATE_LENGTH-1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_t;

    // Misaligned, or any address bit above the implemented word index is set.
    function automatic logic dmem_addr_err(input logic [31:0] addr, input int addr_width);
        return (addr[1:0] != 2'b00) || ((addr >> (addr_width + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// Latency: write and read both take effect on the clock edge; read data appears after that edge.
// Backpressure: none; accepts a write and/or read every cycle, storage is never reset.
module dmem_sram_array
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic [DMEM_BE_LENGTH-1:0] we,
    input  logic                      re,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [31:0]               wdata,
    output logic [31:0]               rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    // Byte-lane writes; only enabled lanes change.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DMEM_BE_LENGTH; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Synchronous read; output holds between reads.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the load/store interface: accepts one request, waits, then responds once.
// Latency: response is WAIT_CYCLES+1 cycles after the accept cycle; one request per WAIT_CYCLES+2 cycles.
// Backpressure: req_ready is high only in IDLE; request inputs are ignored otherwise.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [DMEM_BE_LENGTH-1:0] req_be,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      resp_valid,
    output logic [31:0]               resp_rdata,
    output logic                      resp_err,
    output logic                      busy
);

    localparam logic [DMEM_WAIT_LENGTH-1:0] WAIT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : DMEM_WAIT_LENGTH'(WAIT_CYCLES - 1);

    dmem_state_t                 state_q, state_d;
    logic [DMEM_WAIT_LENGTH-1:0] cnt_q, cnt_d;
    logic                        accept;

    logic                        lat_we;
    logic [DMEM_BE_LENGTH-1:0]   lat_be;
    logic [31:0]                 lat_addr;
    logic [31:0]                 lat_wdata;

    logic                        cur_we;
    logic [DMEM_BE_LENGTH-1:0]   cur_be;
    logic [31:0]                 cur_addr;
    logic [31:0]                 cur_wdata;
    logic                        cur_err;
    logic                        enter_resp;
    logic [DMEM_BE_LENGTH-1:0]   ram_we;
    logic                        ram_re;
    logic [31:0]                 ram_rdata;

    // Next-state, wait counter and handshake outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        req_ready  = 1'b0;
        busy       = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = DMEM_RESP;
                    end else begin
                        state_d = DMEM_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            DMEM_WAIT: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DMEM_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DMEM_RESP: begin
                resp_valid = 1'b1;
                state_d    = DMEM_IDLE;
            end
            default: begin
                state_d = DMEM_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request latches, captured on the accept edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lat_we    <= 1'b0;
            lat_be    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_we    <= req_we;
            lat_be    <= req_be;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    // With zero wait states the commit edge is the accept edge, so the live
    // request must drive the RAM while in IDLE; otherwise the latched copy does.
    always_comb begin
        cur_we    = lat_we;
        cur_be    = lat_be;
        cur_addr  = lat_addr;
        cur_wdata = lat_wdata;
        if (state_q == DMEM_IDLE) begin
            cur_we    = req_we;
            cur_be    = req_be;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end
        cur_err    = dmem_addr_err(cur_addr, ADDR_WIDTH);
        // A reset on the commit edge drops the access entirely.
        enter_resp = rst && (state_d == DMEM_RESP) && (state_q != DMEM_RESP);
        ram_we     = (enter_resp && cur_we && !cur_err) ? cur_be : '0;
        ram_re     = enter_resp && !cur_we && !cur_err;
    end

    dmem_sram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (cur_addr[ADDR_WIDTH+1:2]),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    // Response fields are forced to zero outside the RESP cycle.
    always_comb begin
        resp_err   = resp_valid && dmem_addr_err(lat_addr, ADDR_WIDTH);
        resp_rdata = (resp_valid && !lat_we && !resp_err) ? ram_rdata : 32'd0;
    end

endmodule
